d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop_if.sv | 11 +
 rtl/d_flip_flop.sv | 14 +
 tb/tb_d_flip_flop.sv | 113 +++++++++++
 3 files changed

// File: rtl/d_flip_flop_if.sv
// d_flip_flop_if: data/preset bundle of the D flip-flop (nP, D in; Q, Qbar out)
interface d_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic             nP;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;
    modport master (output nP, D, input Q, Qbar);
    modport slave (input nP, D, output Q, Qbar);
endinterface

// File: rtl/d_flip_flop.sv
// d_flip_flop: rising-edge D flop bank, sync active-low reset C/nR, bus nP/D in, Q/Qbar out
module d_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic          C,
    input  logic          nR,
    d_flip_flop_if.slave  bus
);
    logic [WIDTH-1:0] q_q, q_d;
    always_comb q_d = !nR ? '0 : !bus.nP ? '1 : bus.D;
    always_ff @(posedge C) q_q <= q_d;
    assign bus.Q    = q_q;
    assign bus.Qbar = ~q_q;
endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: vector table, corner sequences and random run against a priority model
module tb_d_flip_flop;
    localparam int W = 4;
    logic C = 1'b0;
    logic nR;
    int n_checks = 0;
    int n_fail = 0;
    d_flip_flop_if #(.WIDTH(W)) bus ();
    d_flip_flop #(.WIDTH(W)) dut (.C(C), .nR(nR), .bus(bus.slave));
    always #5 C = ~C;
    typedef struct {
        logic         r;
        logic         p;
        logic [W-1:0] d;
        logic [W-1:0] q;
    } vec_t;
    vec_t tbl [8];
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask
    task automatic chk_q(input string nm, input logic [W-1:0] exp);
        chk({nm, ".Q"}, bus.Q, exp);
        chk({nm, ".Qbar"}, bus.Qbar, ~exp);
    endtask
    function automatic logic [W-1:0] model(input logic r, input logic p, input logic [W-1:0] d);
        if (r == 1'b0) return '0;
        if (p == 1'b0) return {W{1'b1}};
        return d;
    endfunction
    task automatic step(input logic r, input logic p, input logic [W-1:0] d);
        nR = r;
        bus.nP = p;
        bus.D = d;
        @(posedge C);
        #1;
    endtask
    initial begin
        logic [W-1:0] hold, dr, exp;
        logic rr, pr;
        tbl[0] = '{1'b0, 1'b1, 4'hF, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 4'h0, 4'hF};
        tbl[2] = '{1'b0, 1'b0, 4'hF, 4'h0};
        tbl[3] = '{1'b1, 1'b1, 4'h1, 4'h1};
        tbl[4] = '{1'b1, 1'b1, 4'h0, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 4'hA, 4'hA};
        tbl[6] = '{1'b1, 1'b0, 4'hA, 4'hF};
        tbl[7] = '{1'b1, 1'b1, 4'h5, 4'h5};
        nR = 1'b1;
        bus.nP = 1'b1;
        bus.D = '0;
        @(negedge C);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].p, tbl[i].d);
            chk_q($sformatf("vec%0d", i), tbl[i].q);
        end
        step(1'b1, 1'b0, 4'h0);
        chk_q("preset", 4'hF);
        @(negedge C);
        bus.nP = 1'b1;
        bus.D = 4'h3;
        #1;
        chk_q("preset_release_hold", 4'hF);
        @(posedge C);
        #1;
        chk_q("after_release", 4'h3);
        bus.D = 4'h1;
        @(posedge C);
        #1;
        chk_q("capture_one", 4'h1);
        @(negedge C);
        bus.D = 4'h0;
        #1;
        chk_q("hold_on_fall", 4'h1);
        @(posedge C);
        #1;
        chk_q("capture_zero", 4'h0);
        step(1'b1, 1'b1, 4'h9);
        hold = 4'h9;
        bus.D = 4'h6;
        nR = 1'b0;
        #1 nR = 1'b1;
        bus.nP = 1'b0;
        #1 bus.nP = 1'b1;
        #1;
        chk_q("glitch_clk_high", hold);
        @(negedge C);
        bus.D = 4'hC;
        nR = 1'b0;
        #1 nR = 1'b1;
        bus.nP = 1'b0;
        #1 bus.nP = 1'b1;
        bus.D = 4'h9;
        #1;
        chk_q("glitch_clk_low", hold);
        @(posedge C);
        #1;
        chk_q("after_glitch", hold);
        for (int i = 0; i < 200; i++) begin
            rr = ($urandom_range(0, 5) != 0);
            pr = ($urandom_range(0, 4) != 0);
            dr = W'($urandom);
            exp = model(rr, pr, dr);
            step(rr, pr, dr);
            chk_q($sformatf("rand%0d", i), exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
